serial_out_port: RTL and testbench
==================================

# serial_out_port

Parametrised successor to the 8-bit port-4 output register: a framed, double-buffered serial transmitter fed from the W bus. A byte loaded from WBUS is sent LSB-first on `serial_out` as start bit, data bits, optional parity and stop bit, each held for a programmable number of clocks. A one-deep holding register allows back-to-back frames. READY, ACKNOWLEDGE and OVERRUN flags give the controller a handshake in place of the bare register-bit acknowledge.

## Interface
- `DATA_W`, default 8: data bits per frame and WBUS width; legal values are 1 to 16.
- `BIT_CYCLES`, default 4: clocks per serial bit; must be at least 1.
- `CLK` input, 1 bit: single clock; all state changes on the rising edge.
- `CLR` input, 1 bit: reset, synchronous and active-high; it has priority over every other input.
- `WBUS` input, DATA_W bits: data from the W bus.
- `Lo` input, 1 bit: load WBUS into the port; sampled on the rising edge.
- `serial_out` output, 1 bit: registered line output; idle level is 1.
- `ready` output, 1 bit: holding register empty, so a `Lo` will be accepted.
- `busy` output, 1 bit: a frame is in progress (state is not IDLE).
- `acknowledge` output, 1 bit: one-cycle pulse after each completed frame.
- `overrun` output, 1 bit: sticky flag; a `Lo` was dropped because the holding register was full.

## Operation
- **Reset values:** `serial_out`=1, `ready`=1, `busy`=0, `acknowledge`=0, `overrun`=0; state is IDLE and the holding register is empty.
- **States:**
  - IDLE: line at 1.
  - START: line at 0.
  - DATA: line is shifter[0]; the shifter moves right once per bit.
  - PARITY: present only with the parity option (see Configuration).
  - STOP: line at 1.
- **Bit timing:** each state/bit lasts exactly BIT_CYCLES clocks. A bit-cycle counter runs from 0 to BIT_CYCLES-1. A bit index runs from 0 to DATA_W-1 in DATA.
- **Transitions:** START→DATA; DATA→PARITY (option on) or STOP after bit DATA_W-1; PARITY→STOP. At the end of STOP:
  - holding full: move holding into the shifter, clear holding, go to START with no idle gap.
  - holding empty: go to IDLE.
- **Lo acceptance:**
  - IDLE with holding empty: WBUS goes straight into the shifter and the state becomes START.
  - Otherwise, with holding empty: WBUS goes into the holding register and `ready` drops.
  - Holding full: WBUS is discarded, `overrun` is set and stays set until CLR. The in-flight frame and the holding register are unaffected.
- **Simultaneous events:**
  - `Lo` on the final STOP cycle with holding empty: WBUS goes straight to the shifter, state START (back-to-back frame).
  - `Lo` on the final STOP cycle with holding full: holding goes to the shifter and WBUS goes into the now-free holding register. No overrun.
- **Data path:** the shifter is DATA_W bits. Bits above DATA_W are never driven. WBUS is sampled only on the accept edge; later WBUS changes have no effect.

## Timing
- Registered output: `serial_out` goes to 0 on the same edge that accepts `Lo` from IDLE.
- Frame length is (DATA_W+2)×BIT_CYCLES clocks, or (DATA_W+3)×BIT_CYCLES clocks with parity.
- `acknowledge` is high for exactly the one cycle after the last STOP cycle, including between back-to-back frames.
- `busy` and `ready` are registered and update on the edge that causes the change.
- CLR mid-frame: the next edge forces all reset values; the partial frame is abandoned and the line returns to 1 immediately.

## Configuration
- `SERIAL_OUT_PARITY_EN` defined: a PARITY state follows DATA. It carries the even parity (XOR of the DATA_W data bits) for BIT_CYCLES clocks. The frame is lengthened by BIT_CYCLES.
- Not defined: no PARITY state and no parity logic; DATA goes directly to STOP.

## Test plan
1. DATA_W=8, BIT_CYCLES=2, no parity; `Lo` with WBUS=0x35 in IDLE → `serial_out` pairs 0,1,0,1,0,1,1,0,0,1 (20 clocks). `busy`=1 throughout, then a single `acknowledge` pulse and `busy`=0.
2. Same as 1 with `SERIAL_OUT_PARITY_EN` defined, WBUS=0x35 → parity bit 0 inserted before stop, frame 22 clocks. With WBUS=0x34 the parity bit is 1.
3. Back-to-back: load 0xA5, then 0x5A during the first frame → `ready`=0 until the frame ends. The second start bit follows the first stop bit with no idle gap. Two `acknowledge` pulses, spaced exactly 20 clocks apart.
4. Overrun: with the shifter busy and holding full, `Lo` with 0xFF → `overrun`=1 sticky. The transmitted frames are unchanged and 0xFF is never sent.
5. CLR asserted mid-DATA → next edge `serial_out`=1, `busy`=0, `ready`=1, `overrun`=0. A subsequent `Lo` with 0x01 sends a clean frame.
6. BIT_CYCLES=1, DATA_W=4, WBUS=0xB → line 0,1,1,0,1,1 over 6 clocks, then `acknowledge`.

Source files
------------

// File: rtl/serial_out_port.sv
// serial_out_port: framed, double-buffered LSB-first serial transmitter loaded from WBUS.
// Optional macro SERIAL_OUT_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module serial_out_port #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DATA_W-1:0] WBUS,
    input  logic              Lo,
    output logic              serial_out,
    output logic              ready,
    output logic              busy,
    output logic              acknowledge,
    output logic              overrun
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd4;
`ifdef SERIAL_OUT_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    logic par_q;
`endif

    logic [2:0]        state;
    logic [CW-1:0]     cyc;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shifter;
    logic [DATA_W-1:0] sh_next;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] load_val;
    logic              hold_full;
    logic              bit_end;
    logic              stop_end;
    logic              direct;
    logic              from_hold;
    logic              load_sh;

    assign bit_end   = (cyc == CW'(BIT_CYCLES - 1));
    assign stop_end  = (state == STOP) && bit_end;
    // A new frame starts straight from WBUS when nothing is queued ahead of it.
    assign direct    = Lo && !hold_full && ((state == IDLE) || stop_end);
    assign from_hold = stop_end && hold_full;
    assign load_sh   = direct || from_hold;
    assign load_val  = from_hold ? hold : WBUS;
    assign sh_next   = shifter >> 1;
    assign ready     = !hold_full;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            hold_full <= 1'b0;
            hold      <= '0;
            overrun   <= 1'b0;
        end else if (from_hold) begin
            // Holding drains into the shifter this edge, so a Lo here refills it.
            hold_full <= Lo;
            if (Lo) hold <= WBUS;
        end else if (Lo && !direct) begin
            if (!hold_full) begin
                hold      <= WBUS;
                hold_full <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state       <= IDLE;
            cyc         <= '0;
            idx         <= '0;
            shifter     <= '0;
            serial_out  <= 1'b1;
            acknowledge <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            acknowledge <= stop_end;
            cyc         <= (bit_end || state == IDLE) ? '0 : cyc + CW'(1);
            if (load_sh) begin
                state      <= START;
                shifter    <= load_val;
                serial_out <= 1'b0;
                cyc        <= '0;
`ifdef SERIAL_OUT_PARITY_EN
                par_q      <= ^load_val;
`endif
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state      <= DATA;
                        idx        <= '0;
                        serial_out <= shifter[0];
                    end
                    DATA: begin
                        if (idx == IW'(DATA_W - 1)) begin
`ifdef SERIAL_OUT_PARITY_EN
                            state      <= PARITY;
                            serial_out <= par_q;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            shifter    <= sh_next;
                            serial_out <= sh_next[0];
                            idx        <= idx + IW'(1);
                        end
                    end
`ifdef SERIAL_OUT_PARITY_EN
                    PARITY: begin
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end
`endif
                    default: begin
                        state      <= IDLE;
                        serial_out <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_out_port.sv
// Bench for serial_out_port: two configurations (8b/2clk, 4b/1clk) checked against a waveform-level model.
// Honours SERIAL_OUT_PARITY_EN the same way as the design.
module tb_serial_out_port;
`ifdef SERIAL_OUT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN_A = (8 + 2 + PAR) * 2;

    logic       clk, clr;
    logic [7:0] wb_a;
    logic [3:0] wb_b;
    logic       lo_a, lo_b;
    logic       so_a, rdy_a, bsy_a, ack_a, ovr_a;
    logic       so_b, rdy_b, bsy_b, ack_b, ovr_b;
    int         n_cmp = 0, n_err = 0;
    bit         chk_en = 0;

    serial_out_port #(.DATA_W(8), .BIT_CYCLES(2)) u_a (
        .CLK(clk), .CLR(clr), .WBUS(wb_a), .Lo(lo_a), .serial_out(so_a),
        .ready(rdy_a), .busy(bsy_a), .acknowledge(ack_a), .overrun(ovr_a));
    serial_out_port #(.DATA_W(4), .BIT_CYCLES(1)) u_b (
        .CLK(clk), .CLR(clr), .WBUS(wb_b), .Lo(lo_b), .serial_out(so_b),
        .ready(rdy_b), .busy(bsy_b), .acknowledge(ack_b), .overrun(ovr_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: each frame is a precomputed line waveform, one entry per clock.
    logic [63:0] m_wave [2];
    int          m_len  [2];
    logic [15:0] m_hold [2];
    bit          m_hfull[2];
    bit          m_ovr  [2];
    bit          m_ack  [2];

    function automatic void build(input int s, input logic [15:0] d,
                                  output logic [63:0] w, output int len);
        int dw, bc, n;
        logic [15:0] dm;
        logic sym;
        dw = s ? 4 : 8;
        bc = s ? 1 : 2;
        n  = 0;
        w  = '1;
        dm = d & ((16'h1 << dw) - 16'h1);
        for (int k = 0; k < dw + 2 + PAR; k++) begin
            if (k == 0)                   sym = 1'b0;
            else if (k <= dw)             sym = dm[k-1];
            else if (PAR == 1 && k == dw + 1) sym = ^dm;
            else                          sym = 1'b1;
            for (int r = 0; r < bc; r++) begin
                w[n] = sym;
                n++;
            end
        end
        len = n;
    endfunction

    function automatic void mstep(input int s, input logic c, input logic lo, input logic [15:0] wb);
        if (c) begin
            m_len[s] = 0; m_hfull[s] = 0; m_ovr[s] = 0; m_ack[s] = 0;
        end else begin
            m_ack[s] = (m_len[s] == 1);
            if (m_len[s] > 0) begin
                m_wave[s] = m_wave[s] >> 1;
                m_len[s]--;
            end
            if (m_len[s] == 0 && m_hfull[s]) begin
                build(s, m_hold[s], m_wave[s], m_len[s]);
                m_hfull[s] = 0;
            end
            if (lo) begin
                if (m_len[s] == 0) build(s, wb, m_wave[s], m_len[s]);
                else if (!m_hfull[s]) begin m_hold[s] = wb; m_hfull[s] = 1; end
                else m_ovr[s] = 1;
            end
        end
    endfunction

    always @(posedge clk) begin
        mstep(0, clr, lo_a, {8'h00, wb_a});
        mstep(1, clr, lo_b, {12'h000, wb_b});
    end

    always @(negedge clk) if (chk_en) begin
        check("a_line",  so_a,  (m_len[0] > 0) ? m_wave[0][0] : 1'b1);
        check("a_busy",  bsy_a, m_len[0] > 0);
        check("a_ready", rdy_a, !m_hfull[0]);
        check("a_ack",   ack_a, m_ack[0]);
        check("a_ovr",   ovr_a, m_ovr[0]);
        check("b_line",  so_b,  (m_len[1] > 0) ? m_wave[1][0] : 1'b1);
        check("b_busy",  bsy_b, m_len[1] > 0);
        check("b_ready", rdy_b, !m_hfull[1]);
        check("b_ack",   ack_b, m_ack[1]);
        check("b_ovr",   ovr_b, m_ovr[1]);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic lo, input logic [15:0] d);
        if (s == 0) begin lo_a = lo; wb_a = d[7:0]; end
        else        begin lo_b = lo; wb_b = d[3:0]; end
    endtask

    function automatic logic so_of(input int s);  return s ? so_b  : so_a;  endfunction
    function automatic logic bsy_of(input int s); return s ? bsy_b : bsy_a; endfunction
    function automatic logic ack_of(input int s); return s ? ack_b : ack_a; endfunction

    // line: expected symbols start..stop without parity, bit k = symbol k
    task automatic run_frame(input int s, input logic [15:0] d, input logic [15:0] line, input logic par);
        int dw, bc, nsym;
        logic e;
        dw = s ? 4 : 8;
        bc = s ? 1 : 2;
        nsym = dw + 2 + PAR;
        drive(s, 1'b1, d);
        tick;
        drive(s, 1'b0, 16'h0);
        for (int k = 0; k < nsym; k++) begin
            if (PAR == 1 && k == dw + 1) e = par;
            else if (k == nsym - 1)      e = line[dw+1];
            else                         e = line[k];
            for (int r = 0; r < bc; r++) begin
                check($sformatf("frame%0d_%h_sym%0d", s, d, k), so_of(s), e);
                check($sformatf("frame%0d_busy", s), bsy_of(s), 1'b1);
                tick;
            end
        end
        check($sformatf("frame%0d_ack", s), ack_of(s), 1'b1);
        check($sformatf("frame%0d_idle", s), bsy_of(s), 1'b0);
        tick;
        check($sformatf("frame%0d_ack_once", s), ack_of(s), 1'b0);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] data;
        logic [15:0] line;
        logic        par;
    } vec_t;

    vec_t vecs[8];
    int   nack, t0, spacing;

    initial begin
        vecs[0] = '{0, 16'h35, 16'h26A, 1'b0};
        vecs[1] = '{0, 16'h34, 16'h268, 1'b1};
        vecs[2] = '{0, 16'hFF, 16'h3FE, 1'b0};
        vecs[3] = '{0, 16'h00, 16'h200, 1'b0};
        vecs[4] = '{0, 16'hA5, 16'h34A, 1'b0};
        vecs[5] = '{1, 16'h0B, 16'h036, 1'b1};
        vecs[6] = '{1, 16'h00, 16'h020, 1'b0};
        vecs[7] = '{1, 16'h06, 16'h02C, 1'b0};

        clr = 1'b1; lo_a = 1'b0; lo_b = 1'b0; wb_a = '0; wb_b = '0;
        tick; tick;
        check("rst_line", so_a, 1'b1);  check("rst_ready", rdy_a, 1'b1);
        check("rst_busy", bsy_a, 1'b0); check("rst_ack", ack_a, 1'b0);
        check("rst_ovr", ovr_a, 1'b0);  check("rst_b_line", so_b, 1'b1);
        check("rst_b_busy", bsy_b, 1'b0);
        clr = 1'b0;
        chk_en = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) run_frame(vecs[i].sel, vecs[i].data, vecs[i].line, vecs[i].par);

        // Back-to-back frames through the holding register
        drive(0, 1'b1, 16'hA5); tick;
        drive(0, 1'b0, 16'h0);  tick;
        drive(0, 1'b1, 16'h5A); tick;
        drive(0, 1'b0, 16'h0);
        check("b2b_ready_low", rdy_a, 1'b0);
        nack = 0; t0 = 0; spacing = 0;
        for (int c = 0; c < 200 && nack < 2; c++) begin
            if (ack_a) begin
                if (nack == 0) begin
                    t0 = c;
                    check("b2b_ready_back", rdy_a, 1'b1);
                    check("b2b_no_gap", bsy_a, 1'b1);
                end else begin
                    spacing = c - t0;
                end
                nack++;
            end
            tick;
        end
        check_int("b2b_ack_count", nack, 2);
        check_int("b2b_ack_spacing", spacing, FLEN_A);
        tick;

        // Overrun: third load while one frame runs and holding is full
        drive(0, 1'b1, 16'h11); tick;
        drive(0, 1'b1, 16'h22); tick;
        drive(0, 1'b1, 16'hFF); tick;
        drive(0, 1'b0, 16'h0);
        check("ovr_set", ovr_a, 1'b1);
        check("ovr_hold_kept", rdy_a, 1'b0);
        for (int c = 0; c < 3 * FLEN_A; c++) tick;
        check("ovr_sticky", ovr_a, 1'b1);
        check("ovr_drained", bsy_a, 1'b0);

        // CLR in the middle of the data bits
        drive(0, 1'b1, 16'h35); tick;
        drive(0, 1'b0, 16'h0);
        for (int c = 0; c < 5; c++) tick;
        check("clr_pre_busy", bsy_a, 1'b1);
        clr = 1'b1; tick; clr = 1'b0;
        check("clr_line", so_a, 1'b1);  check("clr_busy", bsy_a, 1'b0);
        check("clr_ready", rdy_a, 1'b1); check("clr_ovr", ovr_a, 1'b0);
        run_frame(0, 16'h01, 16'h202, 1'b1);

        // Random traffic on both ports, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            clr  = ($urandom_range(0, 299) == 0);
            lo_a = ($urandom_range(0, 5) == 0);
            wb_a = 8'($urandom);
            lo_b = ($urandom_range(0, 3) == 0);
            wb_b = 4'($urandom);
            tick;
        end
        clr = 1'b0; lo_a = 1'b0; lo_b = 1'b0;
        for (int c = 0; c < 60; c++) tick;
        check("final_idle_a", bsy_a, 1'b0);
        check("final_idle_b", bsy_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
